// File: rtl/bfp_pkg.sv
// Shared widths and exponent helpers for the bfp_converter blocks.
// Build option BFP_GROUP_ALIGNER_ROUND_EN selects round-half-up alignment in bfp_lane_shift.
package bfp_pkg;

  localparam int BFP_LANES_DEFAULT          = 8;
  localparam int BFP_MANTISSA_WIDTH_DEFAULT = 6;
  localparam int BFP_EXPONENT_WIDTH_DEFAULT = 8;
  localparam int BFP_EXPONENT_WIDTH_MAX     = 32;

  typedef logic [BFP_EXPONENT_WIDTH_MAX-1:0] bfp_exp_t;

  // Exponents are unsigned biased values, so a plain magnitude compare picks the larger one.
  function automatic bfp_exp_t bfp_exp_max(input bfp_exp_t a, input bfp_exp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bfp_lane_shift.sv
// One lane's alignment: arithmetic right shift by the exponent difference with clamping.
// Build option BFP_GROUP_ALIGNER_ROUND_EN adds round-half-up before the shift.
module bfp_lane_shift
  import bfp_pkg::*;
#(
  parameter int MANTISSA_WIDTH = BFP_MANTISSA_WIDTH_DEFAULT,
  parameter int EXPONENT_WIDTH = BFP_EXPONENT_WIDTH_DEFAULT
) (
  input  logic [MANTISSA_WIDTH-1:0] mantissa,
  input  logic [EXPONENT_WIDTH-1:0] diff,
  output logic [MANTISSA_WIDTH-1:0] aligned
);

`ifdef BFP_GROUP_ALIGNER_ROUND_EN
  logic signed [MANTISSA_WIDTH:0] mantissa_ext;
  logic signed [MANTISSA_WIDTH:0] round_bias;
  logic signed [MANTISSA_WIDTH:0] rounded_sum;

  // The extra guard bit keeps +bias from wrapping the largest positive mantissa negative.
  always_comb begin
    mantissa_ext = {mantissa[MANTISSA_WIDTH-1], mantissa};
    round_bias   = '0;
    rounded_sum  = mantissa_ext;
    aligned      = mantissa;
    if (diff == '0) begin
      aligned = mantissa;
    end else if (32'(diff) >= 32'(MANTISSA_WIDTH + 1)) begin
      aligned = '0;
    end else begin
      round_bias  = (MANTISSA_WIDTH + 1)'(1) << (diff - EXPONENT_WIDTH'(1));
      rounded_sum = mantissa_ext + round_bias;
      aligned     = MANTISSA_WIDTH'(rounded_sum >>> diff);
    end
  end
`else
  always_comb begin
    if (32'(diff) >= 32'(MANTISSA_WIDTH)) begin
      aligned = {MANTISSA_WIDTH{mantissa[MANTISSA_WIDTH-1]}};
    end else begin
      aligned = MANTISSA_WIDTH'($signed(mantissa) >>> diff);
    end
  end
`endif

endmodule

// File: rtl/bfp_group_aligner.sv
// Two-stage block-floating-point aligner: stage 1 finds the group max exponent,
// stage 2 shifts every mantissa onto it. Build option: BFP_GROUP_ALIGNER_ROUND_EN.
module bfp_group_aligner
  import bfp_pkg::*;
#(
  parameter int LANES          = BFP_LANES_DEFAULT,
  parameter int MANTISSA_WIDTH = BFP_MANTISSA_WIDTH_DEFAULT,
  parameter int EXPONENT_WIDTH = BFP_EXPONENT_WIDTH_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*EXPONENT_WIDTH-1:0]   in_exponent,
  input  logic [LANES*MANTISSA_WIDTH-1:0]   in_mantissa,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [EXPONENT_WIDTH-1:0]         out_exponent,
  output logic [LANES*MANTISSA_WIDTH-1:0]   out_mantissa
);

  logic                            adv;
  logic [EXPONENT_WIDTH-1:0]       max_tree [LANES];
  logic [EXPONENT_WIDTH-1:0]       in_max;
  logic [LANES*MANTISSA_WIDTH-1:0] aligned;

  logic                            s1_valid_q, s1_valid_d;
  logic [LANES*EXPONENT_WIDTH-1:0] s1_exponent_q, s1_exponent_d;
  logic [LANES*MANTISSA_WIDTH-1:0] s1_mantissa_q, s1_mantissa_d;
  logic [EXPONENT_WIDTH-1:0]       s1_max_q, s1_max_d;
  logic                            out_valid_q, out_valid_d;
  logic [EXPONENT_WIDTH-1:0]       out_exponent_q, out_exponent_d;
  logic [LANES*MANTISSA_WIDTH-1:0] out_mantissa_q, out_mantissa_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || adv;

  // Pairwise reduction in place: after each pass, element j holds the max of a 2*step block.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      max_tree[i] = in_exponent[i*EXPONENT_WIDTH +: EXPONENT_WIDTH];
    end
    for (int step = 1; step < LANES; step = step * 2) begin
      for (int j = 0; j + step < LANES; j = j + 2 * step) begin
        max_tree[j] = EXPONENT_WIDTH'(bfp_exp_max(bfp_exp_t'(max_tree[j]),
                                                  bfp_exp_t'(max_tree[j+step])));
      end
    end
    in_max = max_tree[0];
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [EXPONENT_WIDTH-1:0] lane_diff;
    assign lane_diff = s1_max_q - s1_exponent_q[g*EXPONENT_WIDTH +: EXPONENT_WIDTH];

    bfp_lane_shift #(
      .MANTISSA_WIDTH(MANTISSA_WIDTH),
      .EXPONENT_WIDTH(EXPONENT_WIDTH)
    ) u_shift (
      .mantissa(s1_mantissa_q[g*MANTISSA_WIDTH +: MANTISSA_WIDTH]),
      .diff    (lane_diff),
      .aligned (aligned[g*MANTISSA_WIDTH +: MANTISSA_WIDTH])
    );
  end

  // Output data only moves on a real group so bubbles never disturb the last result.
  always_comb begin
    s1_valid_d     = s1_valid_q;
    s1_exponent_d  = s1_exponent_q;
    s1_mantissa_d  = s1_mantissa_q;
    s1_max_d       = s1_max_q;
    out_valid_d    = out_valid_q;
    out_exponent_d = out_exponent_q;
    out_mantissa_d = out_mantissa_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_exponent_d = in_exponent;
        s1_mantissa_d = in_mantissa;
        s1_max_d      = in_max;
      end
    end
    if (adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_exponent_d = s1_max_q;
        out_mantissa_d = aligned;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_exponent_q <= '0;
      out_mantissa_q <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      out_valid_q    <= out_valid_d;
      out_exponent_q <= out_exponent_d;
      out_mantissa_q <= out_mantissa_d;
    end
  end

  always_ff @(posedge clk) begin
    s1_exponent_q <= s1_exponent_d;
    s1_mantissa_q <= s1_mantissa_d;
    s1_max_q      <= s1_max_d;
  end

  assign out_valid    = out_valid_q;
  assign out_exponent = out_exponent_q;
  assign out_mantissa = out_mantissa_q;

endmodule
